spi_tx_gen: RTL and testbench
=============================

// Module: spi_tx_gen
// PURPOSE
// - SPI master transmit-only message generator (mode 0, CPOL=0/CPHA=0).
// - A one-cycle trigger latches a MESSAGE_WIDTH-bit word; the word is then
//   shifted out with chip select and serial clock generated from clk_in.
// - Sits between the control logic and an external SPI slave (DAC, display, etc.).
// PARAMETERS
// - MESSAGE_WIDTH  16  bits per transaction; legal range >= 1.
// - BIT_DUR         3  clk_in cycles per serial bit; legal range >= 2.
// PORTS
// - clk_in      in   1              system clock; all logic runs on its rising edge.
// - rst_in      in   1              reset, asynchronous, active-low.
// - msg_in      in   MESSAGE_WIDTH  word to send; sampled only on an accepted trigger.
// - trigger_in  in   1              start request; accepted only in IDLE.
// - data_out    out  1              serial data (MOSI).
// - clk_out     out  1              serial clock (SCLK); idles low.
// - sel_out     out  1              chip select, active-low; idles high.
// BEHAVIOUR
// - Interface: one clock (clk_in). Reset is asynchronous and active-low (rst_in).
// - Reset (rst_in=0, asynchronous):
//   - Forces IDLE immediately.
//   - sel_out=1, clk_out=0, data_out=0; shift register and counters cleared.
// - All outputs are registered.
// - States:
//   - IDLE: sel_out=1, clk_out=0, data_out=0.
//   - SEND: transaction in progress.
// - IDLE -> SEND: trigger_in=1 at a clock edge.
//   - That edge latches msg_in into the shift register.
//   - In the next cycle: sel_out=0, data_out=first bit, clk_out=0.
//   - Latency from trigger to select is 1 cycle.
// - Bit timing: each bit lasts exactly BIT_DUR cycles.
//   - clk_out is low for the first BIT_DUR/2 cycles (integer division).
//   - clk_out is high for the remaining BIT_DUR - BIT_DUR/2 cycles.
//   - For BIT_DUR=3: 1 cycle low, 2 cycles high.
// - Data changes only at bit boundaries, while clk_out is low.
//   - Data is stable across the clk_out rising edge, where the slave samples it.
// - Bit order: MSB first, msg[MESSAGE_WIDTH-1] down to msg[0].
// - sel_out stays low for exactly MESSAGE_WIDTH*BIT_DUR cycles.
//   - The message produces exactly MESSAGE_WIDTH clk_out rising edges.
// - SEND -> IDLE: on the edge ending the last bit's final cycle.
//   - Outputs return to sel_out=1, clk_out=0, data_out=0.
//   - At least 1 IDLE cycle always separates transactions.
// - trigger_in in SEND is ignored: no restart, no re-latch.
//   - A trigger in the final SEND cycle is also ignored.
// - msg_in changes after the latch edge do not affect the transfer in progress.
// - Counter widths: $clog2 of BIT_DUR and of MESSAGE_WIDTH, minimum 1 bit each.
// - Reset asserted mid-transaction aborts it at once; outputs take reset values.
// CONFIGURATION
// - SPI_TX_LSB_FIRST_EN defined: bits go out LSB first, msg[0] first.
//   - All timing is unchanged.
// - SPI_TX_LSB_FIRST_EN undefined (default): MSB first as specified above.
// TESTING
// - Idle check: release reset, wait 5 cycles, no trigger
//   -> sel_out=1, clk_out=0, data_out=0 throughout.
// - Basic send: W=16, BIT_DUR=3, msg_in=16'hBEEF, 1-cycle trigger
//   -> sel_out low exactly 48 cycles, starting 1 cycle after the trigger edge.
//   -> data_out is 1011111011101111, each bit held 3 cycles.
//   -> clk_out per bit is 0,1,1; 16 rising edges in total.
// - Even duration: BIT_DUR=2, msg_in=16'h8001
//   -> clk_out per bit is 0,1; sel_out low 32 cycles.
//   -> data_out high only in the first and last bits.
// - Busy trigger: re-pulse trigger_in and change msg_in to 16'h0000 mid-send
//   -> original 16'hBEEF waveform completes unaltered, sel_out low 48 cycles.
// - Mid-send reset: rst_in=0 in the bit-5 window
//   -> sel_out=1, clk_out=0, data_out=0 immediately.
//   -> a later trigger sends a full 48-cycle frame.
// - Macro build: SPI_TX_LSB_FIRST_EN defined, msg_in=16'hBEEF
//   -> data_out is 1111011101111101.

Source files
------------

// File: rtl/spi_tx_gen.sv
// spi_tx_gen -- SPI master, transmit only, mode 0 (CPOL=0, CPHA=0).
//
// A trigger accepted in IDLE latches msg_in. The word is then shifted out on
// data_out, framed by an active-low sel_out and clocked by clk_out. Every bit
// lasts BIT_DUR clk_in cycles. clk_out is low for the first BIT_DUR/2 cycles of
// a bit and high for the rest. data_out changes only at bit boundaries, while
// clk_out is low, so the slave sees stable data at each clk_out rising edge.
//
// Ports:
//   clk_in      system clock; all logic runs on its rising edge
//   rst_in      asynchronous, active-low reset
//   msg_in      word to send; sampled only on an accepted trigger
//   trigger_in  start request; ignored unless the block is idle
//   data_out    serial data (MOSI), registered
//   clk_out     serial clock (SCLK), registered, idles low
//   sel_out     chip select, active-low, registered, idles high
//
// Build option:
//   SPI_TX_LSB_FIRST_EN  when defined, bits go out LSB first. Timing is unchanged.
//                        When undefined (the default), bits go out MSB first.

module spi_tx_gen #(
  parameter int MESSAGE_WIDTH = 16,
  parameter int BIT_DUR       = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [MESSAGE_WIDTH-1:0] msg_in,
  input  logic                     trigger_in,
  output logic                     data_out,
  output logic                     clk_out,
  output logic                     sel_out
);

  localparam int CW = (BIT_DUR > 1) ? $clog2(BIT_DUR) : 1;
  localparam int BW = (MESSAGE_WIDTH > 1) ? $clog2(MESSAGE_WIDTH) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_DUR - 1);
  localparam logic [CW-1:0] CYC_HIGH = CW'(BIT_DUR / 2);  // first clk_out-high cycle
  localparam logic [BW-1:0] BIT_LAST = BW'(MESSAGE_WIDTH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q;
  logic [MESSAGE_WIDTH-1:0] shift_q;  // bits still to send, next one at the head
  logic [CW-1:0]            cyc_q;    // cycle within the bit now on the outputs
  logic [BW-1:0]            bit_q;    // index of the bit now on the outputs
  logic [CW-1:0]            cyc_inc;

  assign cyc_inc = cyc_q + CW'(1);

`ifdef SPI_TX_LSB_FIRST_EN
  function automatic logic head(input logic [MESSAGE_WIDTH-1:0] v);
    return v[0];
  endfunction
  function automatic logic [MESSAGE_WIDTH-1:0] advance(input logic [MESSAGE_WIDTH-1:0] v);
    return v >> 1;
  endfunction
`else
  function automatic logic head(input logic [MESSAGE_WIDTH-1:0] v);
    return v[MESSAGE_WIDTH-1];
  endfunction
  function automatic logic [MESSAGE_WIDTH-1:0] advance(input logic [MESSAGE_WIDTH-1:0] v);
    return v << 1;
  endfunction
`endif

  // The outputs are registered. Each edge loads the values that belong to the
  // next cycle. On the accepting edge, data_out therefore takes the first bit
  // directly from msg_in, and shift_q keeps only the bits that remain.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cyc_q    <= '0;
      bit_q    <= '0;
      data_out <= 1'b0;
      clk_out  <= 1'b0;
      sel_out  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sel_out  <= 1'b1;
          clk_out  <= 1'b0;
          data_out <= 1'b0;
          if (trigger_in) begin
            state_q  <= SEND;
            shift_q  <= advance(msg_in);
            data_out <= head(msg_in);
            sel_out  <= 1'b0;
            cyc_q    <= '0;
            bit_q    <= '0;
          end
        end
        SEND: begin
          if (cyc_q == CYC_LAST) begin
            clk_out <= 1'b0;
            cyc_q   <= '0;
            if (bit_q == BIT_LAST) begin
              // Last cycle of the last bit. The next cycle is IDLE, so any
              // trigger seen in this cycle is dropped.
              state_q  <= IDLE;
              sel_out  <= 1'b1;
              data_out <= 1'b0;
              shift_q  <= '0;
              bit_q    <= '0;
            end else begin
              bit_q    <= bit_q + BW'(1);
              data_out <= head(shift_q);
              shift_q  <= advance(shift_q);
            end
          end else begin
            cyc_q   <= cyc_inc;
            clk_out <= (cyc_inc >= CYC_HIGH);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_gen.sv
// Scoreboard bench for spi_tx_gen. Two instances share all inputs:
// lane 0 uses BIT_DUR=3 and lane 1 uses BIT_DUR=2. For each lane, a reference
// model watches the inputs at every clock edge. When it decides a trigger is
// accepted, it queues the expected start edge and the expected per-cycle
// {clk_out, data_out} stream for the whole frame. A monitor pops from these
// queues whenever it sees sel_out low, and checks idle values at all other times.
module tb_spi_tx_gen;
  localparam int W = 16;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         trigger_in = 1'b0;
  logic [W-1:0] msg_in = '0;
  logic [1:0]   data_o, clk_o, sel_o;

  int n_chk = 0;
  int n_fail = 0;
  int edge_cnt = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %0h expected %0h (edge %0d)", k, nm, act, exp, edge_cnt);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gk
    localparam int BD = (g == 0) ? 3 : 2;
    localparam int N  = W * BD;

    logic [1:0] fq[$];     // expected {sclk, mosi} for each sel-low cycle
    int         sq[$];     // expected edge at which sel_out falls
    int         e = 0;
    int         next_free = 0;
    bit         in_frame = 0;
    int         low_cnt = 0;

    spi_tx_gen #(.MESSAGE_WIDTH(W), .BIT_DUR(BD)) u_dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .msg_in    (msg_in),
      .trigger_in(trigger_in),
      .data_out  (data_o[g]),
      .clk_out   (clk_o[g]),
      .sel_out   (sel_o[g])
    );

    // Reference model. A frame accepted at edge e is low for the N cycles that
    // follow. Another trigger is accepted no earlier than edge e+N+1.
    initial begin
      logic [W-1:0] m;
      logic         b;
      forever begin
        @(posedge clk_in);
        e++;
        if (!rst_in) begin
          fq.delete();
          sq.delete();
          next_free = 0;
        end else if (trigger_in && e >= next_free) begin
          m = msg_in;
          sq.push_back(e);
          for (int i = 0; i < W; i++) begin
`ifdef SPI_TX_LSB_FIRST_EN
            b = m[i];
`else
            b = m[W-1-i];
`endif
            for (int c = 0; c < BD; c++) fq.push_back({(c >= BD / 2), b});
          end
          next_free = e + N + 1;
        end
      end
    end

    // Monitor
    initial begin
      logic [1:0] x;
      forever begin
        @(negedge clk_in);
        if (!rst_in) begin
          in_frame = 0;
          low_cnt  = 0;
          chk(g, "rst_sel", sel_o[g], 1);
          chk(g, "rst_sclk", clk_o[g], 0);
          chk(g, "rst_mosi", data_o[g], 0);
        end else if (sel_o[g] === 1'b0) begin
          if (!in_frame) begin
            in_frame = 1;
            low_cnt  = 0;
            if (sq.size() == 0) chk(g, "unexpected_start", sel_o[g], 1);
            else chk(g, "start_edge", edge_cnt, sq.pop_front());
          end
          low_cnt++;
          if (fq.size() == 0) chk(g, "sel_low_past_frame", sel_o[g], 1);
          else begin
            x = fq.pop_front();
            chk(g, "sclk", clk_o[g], x[1]);
            chk(g, "mosi", data_o[g], x[0]);
          end
        end else begin
          chk(g, "idle_sel", sel_o[g], 1);
          chk(g, "idle_sclk", clk_o[g], 0);
          chk(g, "idle_mosi", data_o[g], 0);
          chk(g, "start_missing", sq.size(), 0);
          if (in_frame) begin
            chk(g, "sel_low_len", low_cnt, N);
            in_frame = 0;
          end
        end
      end
    end
  end

  task automatic pulse(input logic [W-1:0] m);
    @(negedge clk_in);
    trigger_in = 1'b1;
    msg_in     = m;
    @(negedge clk_in);
    trigger_in = 1'b0;
    msg_in     = W'($urandom);
  endtask

  initial begin
    // Hold reset, then leave the block idle for 5 cycles.
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (5) @(negedge clk_in);

    // Basic send. A busy trigger with msg=0 is pulsed in mid-frame.
    pulse(16'hBEEF);
    repeat (20) @(negedge clk_in);
    trigger_in = 1'b1;
    msg_in     = 16'h0000;
    @(negedge clk_in);
    trigger_in = 1'b0;
    repeat (40) @(negedge clk_in);

    // Pattern whose data is high only in the first and last bits.
    pulse(16'h8001);
    repeat (60) @(negedge clk_in);

    // Reset in the bit-5 window of lane 0.
    pulse(16'hBEEF);
    repeat (15) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "async_rst_sel", sel_o[k], 1);
      chk(k, "async_rst_sclk", clk_o[k], 0);
      chk(k, "async_rst_mosi", data_o[k], 0);
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    pulse(16'hBEEF);
    repeat (60) @(negedge clk_in);

    // Trigger held high: frames run back to back, and the trigger is ignored
    // in the final cycle of each frame.
    @(negedge clk_in);
    trigger_in = 1'b1;
    repeat (150) begin
      @(negedge clk_in);
      msg_in = W'($urandom);
    end
    trigger_in = 1'b0;
    repeat (60) @(negedge clk_in);

    // Random triggers and message words.
    repeat (500) begin
      @(negedge clk_in);
      trigger_in = ($urandom_range(0, 7) == 0);
      msg_in     = W'($urandom);
    end
    trigger_in = 1'b0;
    repeat (60) @(negedge clk_in);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
